// File: rtl/fib_stack_unit.sv
// Operand stack for the Fibonacci engine: 3-way tagged source mux feeding a LIFO,
// with a registered presented word and an unsigned threshold flag on it.
module fib_stack_unit #(
  parameter int         DEPTH  = 64,
  parameter logic [9:0] THRESH = 10'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  n_in,
  input  logic [9:0]  dec_in,
  input  logic [9:0]  acc_in,
  input  logic [1:0]  sel,
  input  logic        push,
  input  logic        top,
  input  logic        pop,
  output logic [10:0] data_out,
  output logic        answer,
  output logic        gt,
  output logic        empty,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);

  logic [10:0]   mem [DEPTH];
  logic [AW:0]   sp, sp_m1;
  logic [AW-1:0] top_idx;
  logic [10:0]   w, tos;
  logic          rd, repl, ins, dec;

  always_comb begin
    w = 11'b0;
    case (sel)
      2'b00:   w = {6'b0, n_in};
      2'b01:   w = {1'b0, dec_in};
      2'b10:   w = {1'b1, acc_in};
      default: w = 11'b0;
    endcase
  end

  assign sp_m1   = sp - {{AW{1'b0}}, 1'b1};
  assign top_idx = sp_m1[AW-1:0];
  assign tos     = mem[top_idx];

  assign empty = (sp == '0);
  assign full  = (sp == (AW+1)'(DEPTH));

  // push+pop on a non-empty stack overwrites the top in place; otherwise push
  // takes priority for the pointer so push+top still grows the stack.
  assign rd   = (pop | top) & ~empty;
  assign repl = push & pop & ~empty;
  assign ins  = push & ~full & ~repl;
  assign dec  = pop & ~empty & ~repl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp       <= '0;
      data_out <= 11'b0;
    end else begin
      if (rd) data_out <= tos;
      if (ins)      sp <= sp + {{AW{1'b0}}, 1'b1};
      else if (dec) sp <= sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (repl)     mem[top_idx]    <= w;
      else if (ins) mem[sp[AW-1:0]] <= w;
    end
  end

  assign answer = data_out[10];
  assign gt     = (data_out[9:0] > THRESH);
endmodule

// File: tb/tb_fib_stack_unit.sv
// Scoreboard bench for fib_stack_unit: each command queues its expected
// post-edge state, a monitor pops and compares one edge later.
module tb_fib_stack_unit;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  n_in = '0;
  logic [9:0]  dec_in = '0, acc_in = '0;
  logic [1:0]  sel = '0;
  logic        push = 1'b0, top = 1'b0, pop = 1'b0;
  logic [10:0] data_out;
  logic        answer, gt, empty, full;

  typedef struct {
    logic [10:0] d;
    logic        g;
    logic        e;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  logic cmd_live = 1'b0;
  logic pend = 1'b0;
  int   tests = 0, fails = 0;

  fib_stack_unit #(.DEPTH(DEPTH), .THRESH(10'd1)) dut (
    .clk(clk), .rst_n(rst_n), .n_in(n_in), .dec_in(dec_in), .acc_in(acc_in),
    .sel(sel), .push(push), .top(top), .pop(pop), .data_out(data_out),
    .answer(answer), .gt(gt), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pend <= cmd_live;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard_underrun: output cycle with no expectation queued");
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        tests++;
        if (data_out !== x.d) begin
          fails++; $display("FAIL data_out: got %h want %h", data_out, x.d);
        end
        tests++;
        if (answer !== x.d[10]) begin
          fails++; $display("FAIL answer: got %b want %b", answer, x.d[10]);
        end
        tests++;
        if (gt !== x.g) begin
          fails++; $display("FAIL gt: got %b want %b (data_out %h)", gt, x.g, data_out);
        end
        tests++;
        if (empty !== x.e) begin
          fails++; $display("FAIL empty: got %b want %b", empty, x.e);
        end
        tests++;
        if (full !== x.f) begin
          fails++; $display("FAIL full: got %b want %b", full, x.f);
        end
      end
    end
  end

  task automatic cmd(input logic r, input logic pu, input logic po, input logic tp,
                     input logic [1:0] s, input logic [9:0] v,
                     input logic [10:0] ed, input logic eg, input logic ee, input logic ef);
    exp_t x;
    @(posedge clk); #1;
    rst_n = ~r; push = pu; pop = po; top = tp; sel = s;
    n_in = v[4:0]; dec_in = v; acc_in = v;
    cmd_live = 1'b1;
    x.d = ed; x.g = eg; x.e = ee; x.f = ef;
    exp_q.push_back(x);
  endtask

  initial begin
    // reset then idle
    cmd(1, 0, 0, 0, 2'b00, 10'd0, 11'h000, 0, 1, 0);
    cmd(0, 0, 0, 0, 2'b00, 10'd0, 11'h000, 0, 1, 0);
    // push each source, LIFO pop order
    cmd(0, 1, 0, 0, 2'b00, 10'd5, 11'h000, 0, 0, 0);
    cmd(0, 1, 0, 0, 2'b01, 10'd3, 11'h000, 0, 0, 0);
    cmd(0, 1, 0, 0, 2'b10, 10'd8, 11'h000, 0, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h408, 1, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h003, 1, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h005, 1, 1, 0);
    // top keeps the entry, pop removes it
    cmd(0, 1, 0, 0, 2'b01, 10'd1, 11'h005, 1, 0, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h001, 0, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h001, 0, 1, 0);
    // underflow: all reads ignored
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h001, 0, 1, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h001, 0, 1, 0);
    cmd(0, 0, 1, 1, 2'b00, 10'd0, 11'h001, 0, 1, 0);
    // overflow
    for (int i = 0; i < DEPTH; i++)
      cmd(0, 1, 0, 0, 2'b01, 10'(i), 11'h001, 0, 0, (i == DEPTH-1));
    cmd(0, 1, 0, 0, 2'b01, 10'd99, 11'h001, 0, 0, 1);
    for (int i = DEPTH-1; i >= 0; i--)
      cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'(i), (i > 1), (i == 0), 0);
    // push+pop replaces top, then mid-operation reset
    cmd(0, 1, 0, 0, 2'b01, 10'd2, 11'h000, 0, 0, 0);
    cmd(0, 1, 0, 0, 2'b01, 10'd7, 11'h000, 0, 0, 0);
    cmd(0, 1, 1, 0, 2'b01, 10'd9, 11'h007, 1, 0, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h009, 1, 0, 0);
    cmd(1, 1, 0, 0, 2'b00, 10'd3, 11'h000, 0, 1, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h000, 0, 1, 0);
    // sel=11 zero word and push+top
    cmd(0, 1, 0, 0, 2'b00, 10'd3, 11'h000, 0, 0, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h003, 1, 0, 0);
    cmd(0, 1, 0, 0, 2'b11, 10'h3ff, 11'h003, 1, 0, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h000, 0, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h000, 0, 0, 0);
    cmd(0, 1, 0, 1, 2'b01, 10'd6, 11'h003, 1, 0, 0);
    cmd(0, 0, 0, 1, 2'b00, 10'd0, 11'h006, 1, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h006, 1, 0, 0);
    cmd(0, 0, 1, 0, 2'b00, 10'd0, 11'h003, 1, 1, 0);
    @(posedge clk); #1;
    cmd_live = 1'b0; push = 0; pop = 0; top = 0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fib_stack_unit.md
Name: fib_stack_unit

Overview:
- Operand stack for the hardware Fibonacci engine.
- Selects one of three tagged 11-bit sources (a 3-way input mux), pushes the selected value onto a LIFO, and presents a registered top-of-stack word.
- Also provides an unsigned "greater than threshold" flag on the presented word.
- Sits between the controller FSM (push/top/pop/sel) and the arithmetic datapath (decrement and accumulate paths).

Parameters:
- DEPTH, 64, number of 11-bit stack entries (power of two, ≥4).
- THRESH, 1, 10-bit unsigned constant compared against data_out[9:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- n_in  input  5  problem index N
- dec_in  input  10  decremented operand from datapath
- acc_in  input  10  accumulated partial result
- sel  input  2  source select for push data
- push  input  1  write selected word onto stack
- top  input  1  copy top entry to data_out, no removal
- pop  input  1  copy top entry to data_out and remove it
- data_out  output  11  registered presented word; bit 10 = result tag
- answer  output  1  data_out[10]
- gt  output  1  data_out[9:0] > THRESH, unsigned, combinational
- empty  output  1  stack holds zero entries
- full  output  1  stack holds DEPTH entries

Behaviour:
- Reset (rst_n=0 at clk edge): sp=0, data_out=0, empty=1, full=0. Hence gt=0 and answer=0. Memory contents are don't-care. Reset overrides all commands, including mid-operation.
- Input mux (combinational), producing push word W:
  - sel=00: W={6'b0,n_in}
  - sel=01: W={1'b0,dec_in}
  - sel=10: W={1'b1,acc_in}
  - sel=11: W=11'b0
- Stack pointer sp counts entries, range 0..DEPTH. empty = (sp==0); full = (sp==DEPTH). Both are derived from registered sp.
- Per-cycle actions (all at the rising edge). Let T = mem[sp-1], the current top:
  - push only, not full: mem[sp]<=W; sp<=sp+1; data_out unchanged.
  - push only, full: ignored; no state change.
  - pop only, not empty: data_out<=T; sp<=sp-1.
  - pop, empty: ignored; data_out unchanged.
  - top only, not empty: data_out<=T; sp unchanged.
  - top, empty: ignored.
  - pop and top together: treated as pop.
  - push and pop, not empty: data_out<=T; mem[sp-1]<=W (replace top); sp unchanged.
  - push and pop, empty: behaves as push only.
  - push and top, not empty: data_out<=T (old top); then the push proceeds per push rules.
- Latency:
  - Push data is visible to top/pop on the next cycle.
  - data_out updates one cycle after top/pop is asserted.
  - gt and answer follow data_out combinationally.
- Widths: no arithmetic on data besides the comparison; the comparison uses bits [9:0] only, unsigned.
- Memory is a register array; no read-during-write bypass other than the cases defined above.

Test Plan:
- Reset then idle: rst_n=0 one cycle -> data_out=0, empty=1, full=0, gt=0, answer=0.
- Push sources and LIFO order:
  - Stimulus: n_in=5, sel=00, push; dec_in=3, sel=01, push; acc_in=8, sel=10, push; then three pops.
  - Required data_out sequence: 0x408 (answer=1, gt=1), then 0x003 (gt=1), then 0x005 (gt=1). empty=1 after the third pop.
- top vs pop: push 1, then top -> data_out=1, gt=0, sp stays 1 (empty=0). Then pop -> data_out=1, empty=1.
- Underflow: pop and top while empty -> data_out holds its previous value, sp stays 0.
- Overflow: push DEPTH values 0..DEPTH-1 -> full=1. An extra push is ignored. Pops then return DEPTH-1 down to 0.
- Simultaneous push+pop and mid-operation reset:
  - With stack [2,7] (top 7), push+pop with sel=01, dec_in=9 -> data_out=7, top becomes 9, sp unchanged.
  - Reset asserted next cycle -> empty=1, data_out=0.
